// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss countdown (load/start/pause, borrow chain, stop at 00:00); alarm hold-off built only with `COUNTDOWN_ALARM_EN
module countdown_timer #(
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_min_tens,
    input  logic [3:0] ld_min_ones,
    input  logic [3:0] ld_sec_tens,
    input  logic [3:0] ld_sec_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       load_err,
    output logic       alarm
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state, state_n;
    logic [3:0] mt_n, mo_n, st_n, so_n;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic done_n, load_err_n, zero, dec_zero, ld_ok;
    assign dec_so = sec_ones == 4'd0 ? 4'd9 : sec_ones - 4'd1;
    assign dec_st = sec_ones != 4'd0 ? sec_tens : sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1;
    assign dec_mo = sec_ones != 4'd0 || sec_tens != 4'd0 ? min_ones : min_ones == 4'd0 ? 4'd9 : min_ones - 4'd1;
    assign dec_mt = sec_ones != 4'd0 || sec_tens != 4'd0 || min_ones != 4'd0 ? min_tens : min_tens - 4'd1;
    assign dec_zero = {dec_mt, dec_mo, dec_st, dec_so} == 16'd0;
    assign zero = {min_tens, min_ones, sec_tens, sec_ones} == 16'd0;
    assign ld_ok = ld_min_tens <= 4'd5 && ld_min_ones <= 4'd9 && ld_sec_tens <= 4'd5 && ld_sec_ones <= 4'd9;
    // state, digits and pulse outputs all change together on the edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            min_tens <= mt_n;
            min_ones <= mo_n;
            sec_tens <= st_n;
            sec_ones <= so_n;
            running  <= state_n == RUN;
            done     <= done_n;
            load_err <= load_err_n;
        end
    end
    // next state and digits: RUN only decrements/pauses, every other state only loads/starts
    always_comb begin
        state_n    = state;
        mt_n       = min_tens;
        mo_n       = min_ones;
        st_n       = sec_tens;
        so_n       = sec_ones;
        done_n     = 1'b0;
        load_err_n = 1'b0;
        if (state == RUN) begin
            if (tick) {mt_n, mo_n, st_n, so_n} = {dec_mt, dec_mo, dec_st, dec_so};
            done_n  = tick && dec_zero;
            state_n = done_n ? DONE : pause ? PAUSE : RUN;
        end else if (load) begin
            if (ld_ok) begin
                {mt_n, mo_n, st_n, so_n} = {ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones};
                state_n = IDLE;
            end else begin
                load_err_n = 1'b1;
            end
        end else if (start && state != DONE && !zero) begin
            state_n = RUN;
        end
    end
`ifdef COUNTDOWN_ALARM_EN
    localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS);
    logic [3:0] alarm_cnt;
    logic load_ok;
    assign load_ok = load && ld_ok && state != RUN;
    // alarm rises with done, counts ticks while in DONE and drops after the last one; a valid load clears it
    always_ff @(posedge clk) begin
        if (reset || load_ok) begin
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else if (done_n) begin
            alarm     <= 1'b1;
            alarm_cnt <= '0;
        end else if (state == DONE && alarm && tick) begin
            alarm     <= alarm_cnt + 4'd1 != ALARM_LAST;
            alarm_cnt <= alarm_cnt + 4'd1;
        end
    end
`else
    // held low; ALARM_TICKS is always at least 1 so this comparison is constant 0
    assign alarm = ALARM_TICKS == 0;
`endif
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed test-plan steps then random traffic, checked against a seconds-count model
module tb_countdown_timer;
    localparam int AT = 5;
`ifdef COUNTDOWN_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] ld_min_tens = '0, ld_min_ones = '0, ld_sec_tens = '0, ld_sec_ones = '0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic running, done, load_err, alarm;
    int vectors = 0, miscompares = 0;
    int m_secs = 0, m_state = 0, m_arem = 0;
    bit m_done = 0, m_lerr = 0, m_alarm = 0;

    countdown_timer #(.ALARM_TICKS(AT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .ld_min_tens(ld_min_tens), .ld_min_ones(ld_min_ones),
        .ld_sec_tens(ld_sec_tens), .ld_sec_ones(ld_sec_ones),
        .start(start), .pause(pause),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .done(done), .load_err(load_err), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // model state: 0 idle, 1 run, 2 pause, 3 done; count kept as plain total seconds
    task automatic model(input bit rs, tk, ld, sa, pa, input int lmt, lmo, lst, lso);
        bit ok;
        ok = lmt <= 5 && lmo <= 9 && lst <= 5 && lso <= 9;
        m_done = 0;
        m_lerr = 0;
        if (rs) begin
            m_secs = 0; m_state = 0; m_alarm = 0; m_arem = 0;
        end else if (m_state == 1) begin
            if (tk) m_secs--;
            if (tk && m_secs == 0) begin
                m_state = 3; m_done = 1; m_alarm = ALARM_ON; m_arem = AT;
            end else if (pa) m_state = 2;
        end else begin
            if (m_state == 3 && tk && m_alarm && !(ld && ok)) begin
                m_arem--;
                if (m_arem == 0) m_alarm = 0;
            end
            if (ld) begin
                if (ok) begin
                    m_secs = (lmt * 10 + lmo) * 60 + lst * 10 + lso;
                    m_state = 0; m_alarm = 0;
                end else m_lerr = 1;
            end else if (sa && m_state != 3 && m_secs != 0) m_state = 1;
        end
    endtask

    task automatic step(input bit rs, tk, ld, sa, pa, input int lmt = 0, lmo = 0, lst = 0, lso = 0);
        @(negedge clk);
        reset = rs; tick = tk; load = ld; start = sa; pause = pa;
        ld_min_tens = 4'(lmt); ld_min_ones = 4'(lmo); ld_sec_tens = 4'(lst); ld_sec_ones = 4'(lso);
        model(rs, tk, ld, sa, pa, lmt, lmo, lst, lso);
        @(posedge clk);
        #1;
        chk("min_tens", 8'(min_tens), 8'(m_secs / 600));
        chk("min_ones", 8'(min_ones), 8'((m_secs / 60) % 10));
        chk("sec_tens", 8'(sec_tens), 8'((m_secs % 60) / 10));
        chk("sec_ones", 8'(sec_ones), 8'(m_secs % 10));
        chk("running", 8'(running), 8'(m_state == 1));
        chk("done", 8'(done), 8'(m_done));
        chk("load_err", 8'(load_err), 8'(m_lerr));
        chk("alarm", 8'(alarm), 8'(m_alarm));
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 3, 3, 3, 3);
        // 01:00, start, one tick -> 00:59 still running
        step(0, 0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        chk("tp1_digits", {min_tens, min_ones}, 8'h00);
        chk("tp1_secs", {sec_tens, sec_ones}, 8'h59);
        step(0, 0, 0, 0, 1);
        // 00:02 to expiry, then extra ticks for the alarm window
        step(0, 0, 1, 0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("tp2_done", 8'(done), 8'd1);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < AT + 2; i++) step(0, 1, 0, 0, 0);
        chk("tp2_alarm_off", 8'(alarm), 8'd0);
        // 10:00, tick together with pause, then resume
        step(0, 0, 1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1);
        chk("tp3_paused", {min_tens, min_ones, sec_tens, sec_ones, 4'(running)}, {16'h0959, 4'd0});
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        chk("tp3_resume", {sec_tens, sec_ones}, 8'h58);
        // load ignored in RUN, pause, clear to 00:00, rejected loads, zero start
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 6, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 10);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        // 00:30 in RUN, load 05:00 ignored, then reset with tick
        step(0, 0, 1, 0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0, 5, 0, 0);
        chk("tp5_secs", {sec_tens, sec_ones}, 8'h29);
        step(1, 1, 1, 1, 0, 0, 5, 0, 0);
        chk("tp5_reset", {min_tens, min_ones, sec_tens, sec_ones, 2'(running), 2'(alarm)}, 20'd0);
        // random traffic with short counts so expiry and the alarm window recur
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 1),
                 $urandom_range(0, 9) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 1),
                 $urandom_range(0, 6), $urandom_range(0, 10));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
